// File: rtl/trap_ctrl.sv
// trap_ctrl: machine trap sequencer and trap CSR file.
// Captures exception/mret state, holds the pipeline in flush for FLUSH_CYCLES
// cycles, then issues a one-cycle redirect to the trap vector or to mepc.
module trap_ctrl #(
  parameter int unsigned FLUSH_CYCLES  = 2,
  parameter logic [31:0] RESET_MTVEC   = 32'h0000_0000,
  parameter logic [31:0] ILLEGAL_CAUSE = 32'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        g_exception,
  input  logic [31:0] pc_ex,
  input  logic [31:0] inst_ex,
  input  logic        cmd_mret_ex,
  input  logic        csr_we,
  input  logic [11:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        flush_pipe,
  output logic        jmp_trap,
  output logic [31:0] trap_pc,
  output logic        trap_busy
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;
  localparam logic [3:0]  CNT_INIT  = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FLUSH, JUMP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;

  logic take_exc, take_mret;

  // Requests are only honoured from IDLE; an exception masks a same-cycle mret.
  assign take_exc  = (state_q == IDLE) && g_exception;
  assign take_mret = (state_q == IDLE) && cmd_mret_ex && !g_exception;

  // State and CSR registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      target_q <= 32'd0;
      mepc_q   <= 32'd0;
      mcause_q <= 32'd0;
      mtval_q  <= 32'd0;
      mtvec_q  <= RESET_MTVEC;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
      mtvec_q  <= mtvec_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
    end
  end

  // Next state: CSR writes first, trap/mret capture overrides the fields it owns.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    mtvec_d  = mtvec_q;
    mie_d    = mie_q;
    mpie_d   = mpie_q;

    if (csr_we) begin
      case (csr_waddr)
        A_MSTATUS: begin
          mie_d  = csr_wdata[3];
          mpie_d = csr_wdata[7];
        end
        A_MTVEC:  mtvec_d  = csr_wdata;
        A_MEPC:   mepc_d   = {csr_wdata[31:2], 2'b00};
        A_MCAUSE: mcause_d = csr_wdata;
        A_MTVAL:  mtval_d  = csr_wdata;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (take_exc) begin
          mepc_d   = pc_ex;
          mcause_d = ILLEGAL_CAUSE;
          mtval_d  = inst_ex;
          mpie_d   = mie_q;
          mie_d    = 1'b0;
          // Direct mode only; the pre-write mtvec is the vector.
          target_d = {mtvec_q[31:2], 2'b00};
          cnt_d    = CNT_INIT;
          state_d  = FLUSH;
        end else if (take_mret) begin
          target_d = mepc_q;
          mie_d    = mpie_q;
          mpie_d   = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) state_d = JUMP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      JUMP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; trap_pc is only driven during the redirect.
  always_comb begin
    flush_pipe = (state_q != IDLE);
    trap_busy  = (state_q != IDLE);
    jmp_trap   = (state_q == JUMP);
    trap_pc    = (state_q == JUMP) ? target_q : 32'd0;
  end

  // Combinational CSR read port.
  always_comb begin
    csr_rdata = 32'd0;
    case (csr_raddr)
      A_MSTATUS: csr_rdata = {24'd0, mpie_q, 3'd0, mie_q, 3'd0};
      A_MTVEC:   csr_rdata = mtvec_q;
      A_MEPC:    csr_rdata = mepc_q;
      A_MCAUSE:  csr_rdata = mcause_q;
      A_MTVAL:   csr_rdata = mtval_q;
      default:   csr_rdata = 32'd0;
    endcase
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Consumes the global exception request and the mret command from the EX stage.
- Captures trap state (mepc, mcause, mtval, mstatus.MIE/MPIE) and holds a writable mtvec.
- Sequences a pipeline flush followed by a one-cycle PC redirect to the trap vector or back to mepc.
- Sits between the exception aggregator and the fetch/PC-select logic; it also serves as the machine trap CSR file.

Parameters:
FLUSH_CYCLES, 2, number of cycles flush_pipe is held high before the redirect (1..15)
RESET_MTVEC, 32'h0000_0000, reset value of mtvec
ILLEGAL_CAUSE, 32'd2, mcause value written on an exception

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
g_exception  input  1  exception request from the EX stage
pc_ex  input  32  PC of the instruction in EX
inst_ex  input  32  instruction word in EX, captured into mtval
cmd_mret_ex  input  1  mret executing in EX
csr_we  input  1  CSR write strobe
csr_waddr  input  12  CSR write address
csr_wdata  input  32  CSR write data
csr_raddr  input  12  CSR read address
csr_rdata  output  32  CSR read data, combinational
flush_pipe  output  1  kill IF/ID/EX contents
jmp_trap  output  1  one-cycle PC redirect strobe
trap_pc  output  32  redirect target, valid while jmp_trap=1
trap_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; flush_pipe=0; jmp_trap=0; trap_pc=0; trap_busy=0.
  - mepc=0, mcause=0, mtval=0, MIE=0, MPIE=0, mtvec=RESET_MTVEC, internal counter=0.
- States: IDLE, FLUSH, JUMP. All outputs except csr_rdata are registered or decoded from state and registers only.
- IDLE, g_exception=1 in cycle T. At the edge ending T:
  - mepc<=pc_ex, mcause<=ILLEGAL_CAUSE, mtval<=inst_ex.
  - MPIE<=MIE, MIE<=0.
  - target<={mtvec[31:2],2'b00}; direct mode only, mtvec[1:0] ignored.
  - cnt<=FLUSH_CYCLES-1; state->FLUSH.
- IDLE, cmd_mret_ex=1 and g_exception=0. At the edge:
  - target<=mepc; MIE<=MPIE; MPIE<=1; cnt<=FLUSH_CYCLES-1; state->FLUSH.
- Same-cycle g_exception and cmd_mret_ex: the exception wins and the mret is discarded.
- FLUSH: flush_pipe=1, trap_busy=1. Each cycle, if cnt==0 then state->JUMP, else cnt<=cnt-1. flush_pipe is therefore high for exactly FLUSH_CYCLES cycles.
- JUMP: jmp_trap=1, trap_pc=target, flush_pipe=1, trap_busy=1, for exactly one cycle; then state->IDLE.
- Latency: the first jmp_trap cycle is T+1+FLUSH_CYCLES.
- g_exception or cmd_mret_ex arriving in FLUSH or JUMP is ignored and has no effect on any register.
- CSR write (csr_we=1) is accepted in any state:
  - 0x300 mstatus: bit3->MIE, bit7->MPIE.
  - 0x305 mtvec: full 32 bits.
  - 0x341 mepc: bits[1:0] forced to 0.
  - 0x342 mcause; 0x343 mtval.
  - Other addresses are ignored.
- CSR write in the same cycle as a trap or mret capture: the trap or mret update wins for every field it touches; the CSR write still applies to untouched fields (e.g. mtvec).
- Redirect target after a same-cycle mtvec write: target uses the pre-write mtvec.
- CSR read (csr_rdata), combinational:
  - 0x300 = {24'b0, MPIE, 3'b0, MIE, 3'b0}.
  - 0x305, 0x341, 0x342, 0x343 return the register value.
  - Any other address returns 0.
- Reset asserted mid-FLUSH or mid-JUMP: immediate return to IDLE with all outputs low; no redirect is issued.

Test Plan:
- Reset values: assert rst, then read 0x305/0x341/0x342/0x343/0x300 -> 0/0/0/0/0; flush_pipe, jmp_trap and trap_busy all 0.
- Basic trap:
  - Stimulus: write mtvec=0x0000_0203; MIE=1; pulse g_exception with pc_ex=0x0000_0040, inst_ex=0xFFFF_FFFF, FLUSH_CYCLES=2.
  - Response: flush_pipe high for cycles T+1 and T+2; at T+3 jmp_trap=1 (flush_pipe also 1) with trap_pc=0x0000_0200.
  - Afterwards: mepc=0x40, mcause=2, mtval=0xFFFF_FFFF, mstatus=0x80.
- mret after trap: cmd_mret_ex=1 -> jmp_trap 3 cycles later with trap_pc=0x0000_0040; mstatus reads 0x88.
- Collisions:
  - g_exception and cmd_mret_ex in the same cycle -> trap_pc=mtvec base, mcause=2.
  - A second g_exception during FLUSH -> mepc unchanged, exactly one jmp_trap pulse.
- CSR priority: csr_we to 0x341 with data 0x123 in the same cycle as g_exception (pc_ex=0x80) -> mepc=0x80. A later standalone write of 0x123 -> read returns 0x120.
- Reset mid-operation: rst pulsed during FLUSH -> no jmp_trap pulse ever; state IDLE; all registers return to reset values.
